// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU8 between two requesters. A request is
// accepted in IDLE and its operands are registered onto the alu_* outputs.
// They are held for SETTLE_CYCLES cycles, and then alu_out is captured into
// resp_data. The result is returned with the owning requester id.
//
// Handshake semantics (all three channels): a transfer happens on the rising
// edge where valid && ready are both high. A source may change or drop valid
// at any time; nothing is sampled outside the transfer edge.
//
// Parameters:
//   SETTLE_CYCLES  cycles the alu_* inputs are held before capture (1..15)
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   r0_* / r1_*                 requester channels: valid/ready, a, b, select, cin, bin
//   resp_valid/resp_ready       response channel, with resp_id and resp_data
//   alu_a/alu_b/alu_select/
//   alu_cin/alu_bin             registered operands driven to ALU8
//   alu_out                     ALU8 result (combinational from alu_*)
//   busy                        high whenever the FSM is not IDLE
//   state_dbg                   current FSM state, for checkers
module alu_arbiter #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_valid,
  output logic       r0_ready,
  input  logic [7:0] r0_a,
  input  logic [7:0] r0_b,
  input  logic [3:0] r0_select,
  input  logic       r0_cin,
  input  logic       r0_bin,
  input  logic       r1_valid,
  output logic       r1_ready,
  input  logic [7:0] r1_a,
  input  logic [7:0] r1_b,
  input  logic [3:0] r1_select,
  input  logic       r1_cin,
  input  logic       r1_bin,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [7:0] resp_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_select,
  output logic       alu_cin,
  output logic       alu_bin,
  input  logic [7:0] alu_out,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state;
  logic       last_grant;
  logic [3:0] cnt;
  logic       grant;
  logic       accept;

  // Lone requester wins; on contention the one not granted last wins.
  always_comb begin
    grant = r1_valid;
    if (r0_valid && r1_valid) grant = ~last_grant;
  end

  // Gated by rst so no ready is offered while reset is held.
  assign r0_ready = !rst && (state == IDLE) && !grant && r0_valid;
  assign r1_ready = !rst && (state == IDLE) && grant && r1_valid;
  assign accept   = r0_ready || r1_ready;

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      resp_id    <= 1'b0;
      resp_data  <= 8'd0;
      alu_a      <= 8'd0;
      alu_b      <= 8'd0;
      alu_select <= 4'd0;
      alu_cin    <= 1'b0;
      alu_bin    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (grant) begin
              alu_a      <= r1_a;
              alu_b      <= r1_b;
              alu_select <= r1_select;
              alu_cin    <= r1_cin;
              alu_bin    <= r1_bin;
            end else begin
              alu_a      <= r0_a;
              alu_b      <= r0_b;
              alu_select <= r0_select;
              alu_cin    <= r0_cin;
              alu_bin    <= r0_bin;
            end
            resp_id    <= grant;
            last_grant <= grant;
            cnt        <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          // cnt==1 marks the last settle cycle: capture on its closing edge.
          if (cnt == 4'd1) begin
            resp_data <= alu_out;
            cnt       <= 4'd0;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
